// File: rtl/mipspipe_loader_if.sv
// Word-stream handshake between the host stimulus source and the program/data loader.
interface mipspipe_loader_if #(
    parameter int DATA_W = 32
);
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_data;
    logic              in_last;

    modport master (
        output in_valid,
        output in_data,
        output in_last,
        input  in_ready
    );

    modport slave (
        input  in_valid,
        input  in_data,
        input  in_last,
        output in_ready
    );
endinterface

// File: rtl/mipspipe_loader.sv
// Fills IMEM then DMEM from a word stream, then enables the MIPS core for a fixed
// number of cycles and flags completion.
module mipspipe_loader #(
    parameter int ADDR_W     = 5,
    parameter int DATA_W     = 32,
    parameter int RUN_CYCLES = 16,
    parameter int CNT_W      = 8
) (
    input  logic              clock,
    input  logic              reset,
    mipspipe_loader_if.slave  in_if,
    output logic              imem_we,
    output logic              dmem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              cpu_run,
    output logic [CNT_W-1:0]  run_count,
    output logic              done,
    output logic              overflow
);

    typedef enum logic [1:0] {
        LOAD_I,
        LOAD_D,
        RUN,
        DONE
    } state_t;

    localparam logic [ADDR_W-1:0] ADDR_TOP = '1;
    localparam logic [CNT_W-1:0]  RUN_LAST = CNT_W'(RUN_CYCLES);

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              imem_we_q, imem_we_d;
    logic              dmem_we_q, dmem_we_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
    logic              cpu_run_q, cpu_run_d;
    logic [CNT_W-1:0]  run_count_q, run_count_d;
    logic              done_q, done_d;
    logic              overflow_q, overflow_d;
    logic [CNT_W-1:0]  count_inc;
    logic              ready;
    logic              xfer;
    logic              at_top;

    // Gating with reset keeps the stream stalled during the reset cycle itself.
    assign ready     = ((state_q == LOAD_I) || (state_q == LOAD_D)) && !reset;
    assign xfer      = in_if.in_valid && ready;
    assign at_top    = (addr_q == ADDR_TOP);
    assign count_inc = run_count_q + 1'b1;

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        imem_we_d   = 1'b0;
        dmem_we_d   = 1'b0;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        cpu_run_d   = cpu_run_q;
        run_count_d = run_count_q;
        done_d      = done_q;
        overflow_d  = overflow_q;

        unique case (state_q)
            LOAD_I, LOAD_D: begin
                if (xfer) begin
                    mem_addr_d  = addr_q;
                    mem_wdata_d = in_if.in_data;
                    if (state_q == LOAD_I) begin
                        imem_we_d = 1'b1;
                    end else begin
                        dmem_we_d = 1'b1;
                    end
                    // The top address closes the phase so the counter never wraps.
                    if (in_if.in_last || at_top) begin
                        addr_d = '0;
                        if (!in_if.in_last) begin
                            overflow_d = 1'b1;
                        end
                        state_d = (state_q == LOAD_I) ? LOAD_D : RUN;
                    end else begin
                        addr_d = addr_q + 1'b1;
                    end
                end
            end
            RUN: begin
                // First RUN cycle carries the final DMEM strobe, so the core starts one later.
                if (!cpu_run_q) begin
                    cpu_run_d = 1'b1;
                end else begin
                    run_count_d = count_inc;
                    if (count_inc == RUN_LAST) begin
                        cpu_run_d = 1'b0;
                        done_d    = 1'b1;
                        state_d   = DONE;
                    end
                end
            end
            DONE: begin
            end
            default: begin
                state_d = LOAD_I;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= LOAD_I;
            addr_q      <= '0;
            imem_we_q   <= 1'b0;
            dmem_we_q   <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            cpu_run_q   <= 1'b0;
            run_count_q <= '0;
            done_q      <= 1'b0;
            overflow_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            imem_we_q   <= imem_we_d;
            dmem_we_q   <= dmem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            cpu_run_q   <= cpu_run_d;
            run_count_q <= run_count_d;
            done_q      <= done_d;
            overflow_q  <= overflow_d;
        end
    end

    assign in_if.in_ready = ready;
    assign imem_we        = imem_we_q;
    assign dmem_we        = dmem_we_q;
    assign mem_addr       = mem_addr_q;
    assign mem_wdata      = mem_wdata_q;
    assign cpu_run        = cpu_run_q;
    assign run_count      = run_count_q;
    assign done           = done_q;
    assign overflow       = overflow_q;

endmodule

// File: tb/tb_mipspipe_loader.sv
// Directed self-checking bench for mipspipe_loader: load phases, run budget, reset, DONE.
module tb_mipspipe_loader;

    logic        clock;
    logic        reset;
    logic        imem_we;
    logic        dmem_we;
    logic [4:0]  mem_addr;
    logic [31:0] mem_wdata;
    logic        cpu_run;
    logic [7:0]  run_count;
    logic        done;
    logic        overflow;

    int checks = 0;
    int errors = 0;

    mipspipe_loader_if #(.DATA_W(32)) bus ();

    mipspipe_loader #(
        .ADDR_W     (5),
        .DATA_W     (32),
        .RUN_CYCLES (16),
        .CNT_W      (8)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .in_if     (bus.slave),
        .imem_we   (imem_we),
        .dmem_we   (dmem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .cpu_run   (cpu_run),
        .run_count (run_count),
        .done      (done),
        .overflow  (overflow)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // Drive one cycle of stream inputs and sample 1 time unit after the edge.
    task automatic step(input logic v, input logic [31:0] d, input logic l);
        bus.in_valid = v;
        bus.in_data  = d;
        bus.in_last  = l;
        @(posedge clock);
        #1;
    endtask

    task automatic chk_wr(input string tag, input logic ei, input logic ed,
                          input logic [4:0] ea, input logic [31:0] ewd);
        chk({tag, "_imem_we"}, imem_we, ei);
        chk({tag, "_dmem_we"}, dmem_we, ed);
        if (ei || ed) begin
            chk({tag, "_addr"}, mem_addr, ea);
            chk({tag, "_wdata"}, mem_wdata, ewd);
        end
    endtask

    task automatic do_reset(input string tag);
        reset = 1'b1;
        step(1'b1, 32'hFFFF_FFFF, 1'b1);
        chk({tag, "_rst_ready"}, bus.in_ready, 1'b0);
        chk({tag, "_rst_we"}, {imem_we, dmem_we}, 2'b00);
        chk({tag, "_rst_addr"}, mem_addr, 5'd0);
        chk({tag, "_rst_wdata"}, mem_wdata, 32'd0);
        chk({tag, "_rst_run"}, cpu_run, 1'b0);
        chk({tag, "_rst_count"}, run_count, 8'd0);
        chk({tag, "_rst_done"}, done, 1'b0);
        chk({tag, "_rst_ovf"}, overflow, 1'b0);
        reset = 1'b0;
        #1;
        chk({tag, "_ready_after"}, bus.in_ready, 1'b1);
    endtask

    // Called right after the final DMEM strobe has been checked.
    task automatic run_phase(input string tag);
        int high;
        step(1'b0, 32'h0, 1'b0);
        chk({tag, "_run_start"}, cpu_run, 1'b1);
        chk({tag, "_no_strobe"}, {imem_we, dmem_we}, 2'b00);
        high = 1;
        for (int i = 0; i < 40 && !done; i++) begin
            step(1'b0, 32'h0, 1'b0);
            if (cpu_run) high++;
        end
        chk({tag, "_run_len"}, high, 16);
        chk({tag, "_done"}, done, 1'b1);
        chk({tag, "_run_off"}, cpu_run, 1'b0);
        chk({tag, "_count"}, run_count, 8'd16);
    endtask

    initial begin
        int strobes;
        int readies;
        reset        = 1'b0;
        bus.in_valid = 1'b0;
        bus.in_data  = 32'h0;
        bus.in_last  = 1'b0;

        $display("[TB] test 1: continuous stream");
        do_reset("t1");
        step(1'b1, 32'h1000_0001, 1'b0); chk_wr("t1_i0", 1, 0, 5'd0, 32'h1000_0001);
        step(1'b1, 32'h1000_0002, 1'b0); chk_wr("t1_i1", 1, 0, 5'd1, 32'h1000_0002);
        step(1'b1, 32'h1000_0003, 1'b1); chk_wr("t1_i2", 1, 0, 5'd2, 32'h1000_0003);
        chk("t1_ready_phase", bus.in_ready, 1'b1);
        step(1'b1, 32'h2000_0001, 1'b0); chk_wr("t1_d0", 0, 1, 5'd0, 32'h2000_0001);
        step(1'b1, 32'h2000_0002, 1'b1); chk_wr("t1_d1", 0, 1, 5'd1, 32'h2000_0002);
        chk("t1_last_run", cpu_run, 1'b0);
        chk("t1_last_ready", bus.in_ready, 1'b0);
        run_phase("t1");

        $display("[TB] test 6: stream held in DONE");
        strobes = 0;
        readies = 0;
        for (int i = 0; i < 10; i++) begin
            step(1'b1, 32'hBAD0_0000 + i, 1'b1);
            if (imem_we || dmem_we) strobes++;
            if (bus.in_ready) readies++;
        end
        chk("t6_strobes", strobes, 0);
        chk("t6_ready", readies, 0);
        chk("t6_done", done, 1'b1);
        chk("t6_count", run_count, 8'd16);

        $display("[TB] test 2: toggling valid");
        do_reset("t2");
        step(1'b1, 32'h3000_0000, 1'b0); chk_wr("t2_i0", 1, 0, 5'd0, 32'h3000_0000);
        step(1'b0, 32'h5555_5555, 1'b1); chk_wr("t2_gap0", 0, 0, 5'd0, 32'h0);
        step(1'b1, 32'hDEAD_BEEF, 1'b0); chk_wr("t2_i1", 1, 0, 5'd1, 32'hDEAD_BEEF);
        step(1'b0, 32'h5555_5555, 1'b1); chk_wr("t2_gap1", 0, 0, 5'd0, 32'h0);
        step(1'b1, 32'h3000_0002, 1'b1); chk_wr("t2_i2", 1, 0, 5'd2, 32'h3000_0002);
        step(1'b0, 32'h5555_5555, 1'b1); chk_wr("t2_gap2", 0, 0, 5'd0, 32'h0);
        step(1'b1, 32'h4000_0000, 1'b0); chk_wr("t2_d0", 0, 1, 5'd0, 32'h4000_0000);
        step(1'b0, 32'h5555_5555, 1'b1); chk_wr("t2_gap3", 0, 0, 5'd0, 32'h0);
        chk("t2_gap_ready", bus.in_ready, 1'b1);
        step(1'b1, 32'h4000_0001, 1'b1); chk_wr("t2_d1", 0, 1, 5'd1, 32'h4000_0001);
        chk("t2_last_run", cpu_run, 1'b0);
        run_phase("t2");

        $display("[TB] test 3: IMEM overflow");
        do_reset("t3");
        for (int i = 0; i < 32; i++) begin
            step(1'b1, 32'hA000_0000 + i, 1'b0);
            chk_wr("t3_i", 1, 0, 5'(i), 32'hA000_0000 + i);
            if (i == 30) chk("t3_ovf_early", overflow, 1'b0);
        end
        chk("t3_ovf", overflow, 1'b1);
        chk("t3_ready", bus.in_ready, 1'b1);
        step(1'b1, 32'hB000_0000, 1'b1); chk_wr("t3_d0", 0, 1, 5'd0, 32'hB000_0000);
        chk("t3_ovf_sticky", overflow, 1'b1);
        run_phase("t3");

        $display("[TB] test 4: single-word phases");
        do_reset("t4");
        step(1'b1, 32'hC000_0000, 1'b1); chk_wr("t4_i0", 1, 0, 5'd0, 32'hC000_0000);
        chk("t4_ready_i", bus.in_ready, 1'b1);
        step(1'b1, 32'hC000_0001, 1'b1); chk_wr("t4_d0", 0, 1, 5'd0, 32'hC000_0001);
        chk("t4_ready_d", bus.in_ready, 1'b0);
        chk("t4_ovf", overflow, 1'b0);
        run_phase("t4");

        $display("[TB] test 5: reset mid-phase and mid-run");
        do_reset("t5a");
        step(1'b1, 32'hE000_0000, 1'b1); chk_wr("t5_i0", 1, 0, 5'd0, 32'hE000_0000);
        step(1'b1, 32'hE100_0000, 1'b0); chk_wr("t5_d0", 0, 1, 5'd0, 32'hE100_0000);
        step(1'b1, 32'hE100_0001, 1'b0); chk_wr("t5_d1", 0, 1, 5'd1, 32'hE100_0001);
        do_reset("t5b");
        step(1'b1, 32'hE200_0000, 1'b0); chk_wr("t5_restart", 1, 0, 5'd0, 32'hE200_0000);
        step(1'b1, 32'hE200_0001, 1'b1); chk_wr("t5_i1", 1, 0, 5'd1, 32'hE200_0001);
        step(1'b1, 32'hE300_0000, 1'b1); chk_wr("t5_d", 0, 1, 5'd0, 32'hE300_0000);
        for (int i = 0; i < 30 && run_count != 8'd7; i++) begin
            step(1'b0, 32'h0, 1'b0);
        end
        chk("t5_count7", run_count, 8'd7);
        chk("t5_running", cpu_run, 1'b1);
        do_reset("t5c");
        step(1'b1, 32'hE400_0000, 1'b0); chk_wr("t5_restart2", 1, 0, 5'd0, 32'hE400_0000);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
